// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks register writes in flight between decode and write-back
// and decides, for the decode-stage instruction, whether to stall or where to forward from.
module hazard_scoreboard #(
    parameter int  REG_ADDR_W = 3,
    parameter int  DEPTH      = 3,
    parameter int  FWD        = 0,
    localparam int SEL_W      = $clog2(DEPTH + 1),
    localparam int NUM_REGS   = 2 ** REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  rs_valid,
    input  logic                  rt_valid,
    input  logic                  rd_valid,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic                  stall,
    output logic [SEL_W-1:0]      fwd_rs_sel,
    output logic [SEL_W-1:0]      fwd_rt_sel,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic [15:0]           stall_count
);

    logic [DEPTH-1:0]      slot_valid_r;
    logic [DEPTH-1:0]      slot_load_r;
    logic [REG_ADDR_W-1:0] slot_rd_r [DEPTH];
    logic [15:0]           stall_count_r;

    logic [DEPTH-1:0]      rs_hit_s;
    logic [DEPTH-1:0]      rt_hit_s;
    logic                  any_hit_s;
    logic                  load_use_s;
    logic                  stall_s;
    logic                  issue_s;
    logic [SEL_W-1:0]      rs_sel_s;
    logic [SEL_W-1:0]      rt_sel_s;
    logic [NUM_REGS-1:0]   busy_s;

    // Compare each qualified source identifier against every valid in-flight slot
    always_comb begin
        rs_hit_s = {DEPTH{1'b0}};
        rt_hit_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            rs_hit_s[i] = rs_valid & slot_valid_r[i] & (slot_rd_r[i] == rs);
            rt_hit_s[i] = rt_valid & slot_valid_r[i] & (slot_rd_r[i] == rt);
        end
    end

    // Stall decision; with forwarding only a load still in EX forces a bubble
    always_comb begin
        any_hit_s  = (|rs_hit_s) | (|rt_hit_s);
        load_use_s = slot_load_r[0] & (rs_hit_s[0] | rt_hit_s[0]);
        if (id_valid && !flush) begin
            if (FWD != 0) begin
                stall_s = load_use_s;
            end else begin
                stall_s = any_hit_s;
            end
        end else begin
            stall_s = 1'b0;
        end
        issue_s = id_valid & rd_valid & ~stall_s & ~flush;
    end

    // Youngest match wins: scan oldest to youngest so the lowest index is written last
    always_comb begin
        rs_sel_s = {SEL_W{1'b0}};
        rt_sel_s = {SEL_W{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rs_hit_s[i]) begin
                rs_sel_s = SEL_W'(i + 1);
            end else begin
                rs_sel_s = rs_sel_s;
            end
            if (rt_hit_s[i]) begin
                rt_sel_s = SEL_W'(i + 1);
            end else begin
                rt_sel_s = rt_sel_s;
            end
        end
    end

    // One busy bit per architectural register with a pending write
    always_comb begin
        busy_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid_r[i]) begin
                busy_s[slot_rd_r[i]] = 1'b1;
            end else begin
                busy_s = busy_s;
            end
        end
    end

    // Slot shift register and saturating stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid_r  <= {DEPTH{1'b0}};
            slot_load_r   <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                slot_rd_r[i] <= {REG_ADDR_W{1'b0}};
            end
            stall_count_r <= 16'h0000;
        end else begin
            slot_valid_r[0] <= issue_s;
            slot_load_r[0]  <= id_is_load;
            slot_rd_r[0]    <= rd;
            for (int i = 1; i < DEPTH; i++) begin
                slot_valid_r[i] <= slot_valid_r[i-1];
                slot_load_r[i]  <= slot_load_r[i-1];
                slot_rd_r[i]    <= slot_rd_r[i-1];
            end
            if (stall_s && (stall_count_r != 16'hFFFF)) begin
                stall_count_r <= stall_count_r + 16'h0001;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign stall       = stall_s;
    assign fwd_rs_sel  = ((FWD != 0) && !stall_s) ? rs_sel_s : {SEL_W{1'b0}};
    assign fwd_rt_sel  = ((FWD != 0) && !stall_s) ? rt_sel_s : {SEL_W{1'b0}};
    assign busy_mask   = busy_s;
    assign stall_count = stall_count_r;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameters SHALL be, one per line:
- REG_ADDR_W, 3, register-identifier width; register count is 2^REG_ADDR_W.
- DEPTH, 3, number of in-flight stages between decode and register-file write (slot 0 = EX, slot DEPTH-1 = WB); minimum 1.
- FWD, 0, 0 = stall-only mode, 1 = forwarding mode.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  decode-stage instruction present.
- rs, rt, rd  in  REG_ADDR_W each  decoded source/source/destination identifiers.
- rs_valid, rt_valid, rd_valid  in  1 each  identifier qualifiers.
- id_is_load  in  1  decode instruction is a load.
- flush  in  1  discard decode-stage instruction this cycle.
- stall  out  1  hold decode stage; insert a bubble.
- fwd_rs_sel, fwd_rt_sel  out  clog2(DEPTH+1)  forward source (0 = register file, k = slot k-1).
- busy_mask  out  2^REG_ADDR_W  bit r set when a write to r is in flight.
- stall_count  out  16  saturating count of stalled cycles.

Function
REQ-003 The block SHALL hold DEPTH slots, each {valid, rd, is_load}, advancing one slot per cycle: slot[i+1] <= slot[i].
REQ-004 Slot 0 SHALL load {1, rd, id_is_load} when id_valid & rd_valid & !stall & !flush; otherwise it SHALL load a bubble (valid=0).
REQ-005 The entry leaving slot DEPTH-1 SHALL be dropped; the register file has no write-through, so a match in slot DEPTH-1 counts as a hazard.
REQ-006 A source SHALL match slot i when its valid bit is set, slot i is valid, and the identifiers are equal; register 0 gets no special treatment.
REQ-007 FWD=0: stall SHALL be 1 when id_valid & !flush and either source matches any slot.
REQ-008 FWD=1: stall SHALL be 1 only when id_valid & !flush and either source matches slot 0 with is_load=1 (load-use).
REQ-009 FWD=1: fwd_*_sel SHALL be 1 + the lowest-index (youngest) matching slot, else 0; in FWD=0, and whenever stall=1, both SHALL be 0.
REQ-010 stall, fwd_*_sel and busy_mask SHALL be combinational from the slots and current inputs, with zero-cycle latency.
REQ-011 flush SHALL force stall=0 and SHALL not disturb older in-flight slots.
REQ-012 busy_mask bit r SHALL be the OR over valid slots of (slot.rd == r).
REQ-013 stall_count SHALL increment on each clock edge where stall=1 and saturate at 16'hFFFF.
REQ-014 With id_valid=0, stall SHALL be 0 and slots SHALL still advance.

Reset
REQ-015 rst=1 SHALL immediately clear all slot valid bits and stall_count, regardless of clk.
REQ-016 During and after reset, stall, fwd_rs_sel, fwd_rt_sel, busy_mask and stall_count SHALL be 0.
REQ-017 Reset asserted mid-stall SHALL drop stall to 0 within the same cycle; the first post-reset decode SHALL see an empty scoreboard.

Verification (DEPTH=3, REG_ADDR_W=3)
REQ-018 The bench SHALL cover these directed scenarios:
- FWD=0, write r3 issued, then a reader of rs=r3 held valid -> stall=1 for exactly 3 cycles, issued on the 4th; stall_count=3; busy_mask=8'h08 during the stall.
- FWD=1, load to r2, then reader rs=r2 -> stall=1 for 1 cycle, then stall=0 and fwd_rs_sel=2.
- FWD=1, ALU write r4, then reader rt=r4 -> stall=0, fwd_rt_sel=1, fwd_rs_sel=0.
- FWD=1, writes to r5 in slot 0 and slot 2, reader rs=r5 -> fwd_rs_sel=1.
- FWD=0, flush=1 with a dependent instruction -> stall=0; next cycle slot 0 is a bubble; busy_mask shows only older writes.
- Async reset pulsed between clock edges during a stall -> stall, busy_mask and stall_count read 0 before the next edge; saturation checked by forcing 65536+ stall cycles -> stall_count=16'hFFFF.
